// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - tv80s bus slave: decodes CPU strobes into single-cycle RAM/IO requests
module z80_bus_responder #(
    parameter logic [2:0] MEM_WAIT = 3'd0,
    parameter logic [2:0] IO_WAIT  = 3'd1,
    parameter logic [7:0] INTA_VEC = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_re,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_rd,
    output logic        io_wr,
    input  logic [7:0]  io_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, n_q, n_d;
    logic        rd_mem_q, rd_mem_d, rd_io_q, rd_io_d;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic        wait_n_q, wait_n_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d, io_addr_q, io_addr_d, io_wdata_q, io_wdata_d;
    logic        ram_re_q, ram_re_d, ram_we_q, ram_we_d, io_rd_q, io_rd_d, io_wr_q, io_wr_d;
    logic        bus_err_q, bus_err_d;

    logic inta, mem_ok, memrd, memwr, io_ok, iord, iowr, clash, wait_done;

    // mreq_n and iorq_n both low outside INTA is a bus fault; it is served as an I/O cycle
    assign clash     = !mreq_n && !iorq_n && m1_n;
    assign inta      = !iorq_n && !m1_n;
    assign mem_ok    = !mreq_n && iorq_n && rfsh_n;
    assign memrd     = mem_ok && !rd_n;
    assign memwr     = mem_ok && rd_n && !wr_n;
    assign io_ok     = !iorq_n && m1_n;
    assign iord      = io_ok && !rd_n;
    assign iowr      = io_ok && rd_n && !wr_n;
    assign wait_done = ({1'b0, cnt_q} + 4'd1) >= {1'b0, n_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        rd_mem_d    = rd_mem_q;
        rd_io_d     = rd_io_q;
        cpu_di_d    = cpu_di_q;
        wait_n_d    = wait_n_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        ram_re_d    = 1'b0;
        ram_we_d    = 1'b0;
        io_rd_d     = 1'b0;
        io_wr_d     = 1'b0;
        bus_err_d   = bus_err_q | clash;

        case (state_q)
            S_IDLE: begin
                if (inta || memrd || memwr || iord || iowr) begin
                    state_d  = S_ACCESS;
                    cnt_d    = 3'd0;
                    n_d      = (memrd || memwr) ? MEM_WAIT : IO_WAIT;
                    wait_n_d = ((memrd || memwr) ? MEM_WAIT : IO_WAIT) == 3'd0;
                    rd_mem_d = memrd && !inta;
                    rd_io_d  = iord;
                    if (inta) begin
                        cpu_di_d = INTA_VEC;
                    end else if (memrd || memwr) begin
                        ram_addr_d = A;
                        ram_re_d   = memrd;
                        ram_we_d   = memwr;
                        if (memwr) ram_wdata_d = dout;
                    end else begin
                        io_addr_d = A[7:0];
                        io_rd_d   = iord;
                        io_wr_d   = iowr;
                        if (iowr) io_wdata_d = dout;
                    end
                end
            end
            S_ACCESS, S_WAIT: begin
                if (state_q == S_ACCESS) begin
                    if (rd_mem_q) cpu_di_d = ram_rdata;
                    if (rd_io_q)  cpu_di_d = io_rdata;
                end
                // wait_n releases on the edge that completes the N-th low cycle
                if (wait_done) begin
                    wait_n_d = 1'b1;
                    state_d  = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (mreq_n && iorq_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            rd_mem_q    <= 1'b0;
            rd_io_q     <= 1'b0;
            cpu_di_q    <= 8'hFF;
            wait_n_q    <= 1'b1;
            ram_addr_q  <= 16'h0000;
            ram_wdata_q <= 8'h00;
            io_addr_q   <= 8'h00;
            io_wdata_q  <= 8'h00;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            rd_mem_q    <= rd_mem_d;
            rd_io_q     <= rd_io_d;
            cpu_di_q    <= cpu_di_d;
            wait_n_q    <= wait_n_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            io_rd_q     <= io_rd_d;
            io_wr_q     <= io_wr_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign cpu_di    = cpu_di_q;
    assign wait_n    = wait_n_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_re    = ram_re_q;
    assign ram_we    = ram_we_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;
    assign io_rd     = io_rd_q;
    assign io_wr     = io_wr_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb/tb_z80_bus_responder.sv - scoreboard bench for z80_bus_responder with a per-bus-cycle model
module tb_z80_bus_responder;

    localparam logic [2:0] MW = 3'd0;
    localparam logic [2:0] IW = 3'd2;
    localparam logic [7:0] IV = 8'hFF;

    localparam int K_MRD = 0, K_MWR = 1, K_IRD = 2, K_IWR = 3, K_INTA = 4, K_RFSH = 5;
    localparam int K_BERD = 6, K_BEWR = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1, rfsh_n = 1'b1;
    logic [7:0]  cpu_di;
    logic        wait_n;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, io_addr, io_wdata;
    logic        ram_re, ram_we, io_rd, io_wr, bus_err;
    logic [7:0]  ram_rdata = 8'h00, io_rdata = 8'h00;

    z80_bus_responder #(.MEM_WAIT(MW), .IO_WAIT(IW), .INTA_VEC(IV)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .dout(dout),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .cpu_di(cpu_di), .wait_n(wait_n),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
        .ram_rdata(ram_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr), .io_rdata(io_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pmask;   // {ram_re, ram_we, io_rd, io_wr}
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          waits;
        logic [7:0]  di;
        logic        berr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    logic in_cycle = 1'b0;

    // reference model state: what the CPU should see on cpu_di and bus_err
    logic [7:0] m_di = 8'hFF;
    logic       m_berr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: accumulates what the DUT did during one bus cycle, compares at strobe release
    logic        was_in = 1'b0;
    logic [3:0]  seen;
    int          npulse, nwait;
    logic [15:0] cap_ram_addr;
    logic [7:0]  cap_io_addr, cap_ram_wdata, cap_io_wdata;

    always @(negedge clk) begin
        if (in_cycle) begin
            if (!was_in) begin
                seen = 4'b0; npulse = 0; nwait = 0; was_in = 1'b1;
            end
            if (ram_re || ram_we || io_rd || io_wr) begin
                seen   = seen | {ram_re, ram_we, io_rd, io_wr};
                npulse = npulse + int'(ram_re) + int'(ram_we) + int'(io_rd) + int'(io_wr);
                cap_ram_addr  = ram_addr;
                cap_io_addr   = io_addr;
                cap_ram_wdata = ram_wdata;
                cap_io_wdata  = io_wdata;
            end
            if (!wait_n) nwait++;
        end else if (was_in) begin
            was_in = 1'b0;
            if (q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", 32'(seen), 32'(e.pmask));
                chk("pulse_count", npulse, (e.pmask != 4'b0) ? 1 : 0);
                if (e.pmask[3:2] != 2'b0) chk("ram_addr", 32'(cap_ram_addr), 32'(e.addr));
                if (e.pmask[1:0] != 2'b0) chk("io_addr", 32'(cap_io_addr), 32'(e.addr));
                if (e.pmask[2]) chk("ram_wdata", 32'(cap_ram_wdata), 32'(e.wdata));
                if (e.pmask[0]) chk("io_wdata", 32'(cap_io_wdata), 32'(e.wdata));
                chk("wait_cycles", nwait, e.waits);
                chk("cpu_di", 32'(cpu_di), 32'(e.di));
                chk("bus_err", 32'(bus_err), 32'(e.berr));
            end
        end
    end

    task automatic do_cycle(input int kind, input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] rdat, input int extra);
        exp_t e;
        int   edges;
        e.pmask = 4'b0; e.waits = 0;
        case (kind)
            K_MRD:  begin e.pmask = 4'b1000; e.waits = int'(MW); m_di = rdat; end
            K_MWR:  begin e.pmask = 4'b0100; e.waits = int'(MW); end
            K_IRD:  begin e.pmask = 4'b0010; e.waits = int'(IW); m_di = rdat; end
            K_IWR:  begin e.pmask = 4'b0001; e.waits = int'(IW); end
            K_INTA: begin e.waits = int'(IW); m_di = IV; end
            K_BERD: begin e.pmask = 4'b0010; e.waits = int'(IW); m_di = rdat; m_berr = 1'b1; end
            K_BEWR: begin e.pmask = 4'b0001; e.waits = int'(IW); m_berr = 1'b1; end
            default: ;
        endcase
        e.addr  = (e.pmask[3:2] != 2'b0) ? a : {8'h00, a[7:0]};
        e.wdata = d;
        e.di    = m_di;
        e.berr  = m_berr;
        q.push_back(e);

        A = a; dout = d; ram_rdata = rdat; io_rdata = rdat;
        mreq_n = !(kind == K_MRD || kind == K_MWR || kind == K_RFSH || kind == K_BERD || kind == K_BEWR);
        iorq_n = !(kind == K_IRD || kind == K_IWR || kind == K_INTA || kind == K_BERD || kind == K_BEWR);
        rd_n   = !(kind == K_MRD || kind == K_IRD || kind == K_BERD);
        wr_n   = !(kind == K_MWR || kind == K_IWR || kind == K_BEWR);
        m1_n   = !(kind == K_INTA);
        rfsh_n = !(kind == K_RFSH);
        in_cycle = 1'b1;

        edges = 0;
        do begin
            @(posedge clk); #2;
            edges++;
        end while ((!wait_n || edges < 2) && edges < 30);
        if (edges >= 30) chk("wait_timeout", 32'(edges), 32'd0);
        // read data must be held by the DUT even when the source changes afterwards
        ram_rdata = ~rdat; io_rdata = ~rdat;
        repeat (extra) begin @(posedge clk); #2; end

        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
        in_cycle = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cpu_di", 32'(cpu_di), 32'hFF);
        chk("rst_wait_n", 32'(wait_n), 32'd1);
        chk("rst_pulses", 32'({ram_re, ram_we, io_rd, io_wr}), 32'd0);
        chk("rst_addrs", {ram_addr, io_addr, 8'h00}, 32'd0);
        chk("rst_wdata", 32'({ram_wdata, io_wdata}), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #2;

        do_cycle(K_MRD,  16'hDCA6, 8'h00, 8'h49, 0);
        do_cycle(K_MWR,  16'h0100, 8'h9B, 8'h00, 2);
        do_cycle(K_RFSH, 16'h0001, 8'h00, 8'h77, 0);
        do_cycle(K_IRD,  16'h12FE, 8'h00, 8'h5A, 1);
        do_cycle(K_INTA, 16'h0038, 8'h00, 8'h33, 0);

        for (int i = 0; i < 40; i++) begin
            int r, k;
            r = int'($urandom_range(0, 19));
            k = (r < 18) ? (r % 6) : (6 + r - 18);
            do_cycle(k, 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        // reset in the middle of an I/O write wait aborts the cycle at once
        A = 16'h3344; dout = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk); #2;
        chk("abort_pre_io_wr", 32'(io_wr), 32'd1);
        chk("abort_pre_wait_n", 32'(wait_n), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_wait_n", 32'(wait_n), 32'd1);
        chk("abort_io_wr", 32'(io_wr), 32'd0);
        chk("abort_bus_err", 32'(bus_err), 32'd0);
        iorq_n = 1'b1; wr_n = 1'b1;
        m_di = 8'hFF; m_berr = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        do_cycle(K_MRD, 16'h8001, 8'h00, 8'hC3, 1);
        do_cycle(K_IWR, 16'hAB10, 8'h6E, 8'h00, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
